operator_test_fsm: RTL and testbench
====================================

Name: operator_test_fsm

Overview:
- Parametrised successor to the single-state operator test FSM.
- Accepts operand pairs over a valid/ready input stream and applies a selectable binary operator.
- Results go into a circular result array, which drains through a valid/ready output port.
- Used as a self-checking operator harness for compiler-generated RTL unit tests.

Parameters:
DATA_W, 32, width of operands, results and array entries
DEPTH, 8, result array entries (power of two, >=2)
STATE_W, 8, width of the fsmState register

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; all state is cleared while low
in1  input  DATA_W  operand data
in1_valid  input  1  in1 holds a valid operand
in1_ready  output  1  block accepts an operand this cycle
op  input  3  operator select, sampled with the second operand (B)
out1  output  DATA_W  result at the head of the array
out1_valid  output  1  array is non-empty
out1_ready  input  1  consumer accepts out1 this cycle
count  output  $clog2(DEPTH)+1  number of stored results

Behaviour:
- Reset (reset low, asynchronous):
  - fsmState=INITIAL; wr_ptr, rd_ptr and count = 0.
  - All arr entries = 0; captured A, B and op = 0.
  - Therefore in1_ready=0, out1_valid=0, out1=0.
- States and encodings: INITIAL=0, START=1, OPB=2, EXEC=3.
- INITIAL: in1_ready=0; always moves to START on the next edge, so the first handshake is possible on the 2nd edge after reset is released.
- START:
  - in1_ready = (count != DEPTH).
  - On in1_valid & in1_ready: capture A=in1, go to OPB.
- OPB:
  - in1_ready=1.
  - On in1_valid: capture B=in1 and op, go to EXEC.
  - With no valid, stay in OPB; A is held.
- EXEC:
  - in1_ready=0.
  - Write arr[wr_ptr] = f(op,A,B); wr_ptr increments and wraps modulo DEPTH.
  - count increments; go to START.
  - Full can only be detected in START, so EXEC never writes into a full array.
- Operators (results are DATA_W wide; compare and logical results are zero-extended 0/1):
  - 0 ADD: A+B mod 2^DATA_W.
  - 1 SUB: A-B mod 2^DATA_W.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 EQ: A==B.
  - 6 LAND: (A!=0)&&(B!=0).
  - 7 LT: A<B, unsigned by default.
- Output side:
  - out1 = arr[rd_ptr], read combinationally; out1_valid = (count!=0).
  - Pop on out1_valid & out1_ready: rd_ptr increments and wraps; count decrements.
  - out1_ready while empty has no effect.
- Simultaneous EXEC write and pop in one cycle: count unchanged; both pointers advance.
- Latency: second-operand handshake to out1_valid is 2 edges when the array was empty.
- Throughput: one result per 3 cycles maximum.
- out1 holds its value while out1_valid=1 and out1_ready=0.
- in1_valid while in1_ready=0 is ignored; in1 is not captured.
- Reset mid-operation: a partial pair and all stored results are discarded; no output glitch beyond the asynchronous clear.

Optional Feature:
- Macro OPERATOR_TEST_SIGNED_EN.
- Defined:
  - op 7 is a signed (two's complement) less-than.
  - op 6 is redefined as SLT-or-equal (A<=B, signed).
- Undefined:
  - op 7 is unsigned less-than; op 6 is LAND as listed above.
- No port or state differences between the two builds.

Test Plan:
- Release reset, then drive in1=5 then in1=7 with op=0, valid held -> in1_ready low for 1 cycle after reset; out1=12 and out1_valid=1 two edges after the 2nd handshake; count=1.
- Operand pairs (0,1) op=5 and (3,3) op=5 -> array holds 0 then 1; drain with out1_ready=1 -> out1 sequence 0,1; count returns to 0.
- Fill 8 results with out1_ready=0 -> count=8; in1_ready=0 in START; extra in1_valid ignored; pop one -> in1_ready=1 next cycle.
- (0xFFFFFFFF,1) op=0 and (0,1) op=1 -> 0x00000000 and 0xFFFFFFFF (wrap-around); (0xFFFFFFFF,1) op=7 -> 0 unsigned, 1 with OPERATOR_TEST_SIGNED_EN.
- Keep out1_ready=1 while streaming pairs so an EXEC write coincides with a pop -> count constant; pointers wrap past 7 with no data loss over 20 results.
- Assert reset while in OPB with 3 results stored -> out1_valid=0, count=0, out1=0 immediately; the next pair is processed normally from START.

Source files
------------

// File: rtl/operator_test_fsm.sv
// rtl/operator_test_fsm.sv - operand-pair operator FSM with circular result array
//
// Accepts two operands (A then B) over a valid/ready input, applies the operator
// selected by op (sampled with B), and stores the result in a DEPTH-entry
// circular array that drains through a valid/ready output.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears all state
//   in1         operand data
//   in1_valid   in1 carries an operand
//   in1_ready   operand accepted this cycle when in1_valid is also high
//   op          operator select, captured together with operand B
//   out1        result at the head of the array
//   out1_valid  array is non-empty
//   out1_ready  consumer takes out1 this cycle
//   count       number of stored results
//
// Build option OPERATOR_TEST_SIGNED_EN: op 7 becomes signed less-than and
// op 6 becomes signed less-than-or-equal. Ports and state are identical in
// both builds.
module operator_test_fsm #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int STATE_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in1,
    input  logic                       in1_valid,
    output logic                       in1_ready,
    input  logic [2:0]                 op,
    output logic [DATA_W-1:0]          out1,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [STATE_W-1:0] {
        INITIAL = STATE_W'(0),
        START   = STATE_W'(1),
        OPB     = STATE_W'(2),
        EXEC    = STATE_W'(3)
    } state_t;

    state_t             fsm_state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [2:0]         op_q;
    logic [DATA_W-1:0]  arr [DEPTH];
    logic [DATA_W-1:0]  exec_result;
    logic               push;
    logic               pop;

    // Full is only checked in START; EXEC always follows a START that saw room.
    always_comb begin
        in1_ready = 1'b0;
        case (fsm_state)
            START:   in1_ready = (count != CNT_W'(DEPTH));
            OPB:     in1_ready = 1'b1;
            default: in1_ready = 1'b0;
        endcase
    end

    assign out1       = arr[rd_ptr];
    assign out1_valid = (count != '0);
    assign push       = (fsm_state == EXEC);
    assign pop        = out1_valid && out1_ready;

    always_comb begin
        exec_result = '0;
        case (op_q)
            3'd0: exec_result = a_q + b_q;
            3'd1: exec_result = a_q - b_q;
            3'd2: exec_result = a_q & b_q;
            3'd3: exec_result = a_q | b_q;
            3'd4: exec_result = a_q ^ b_q;
            3'd5: exec_result = DATA_W'(a_q == b_q);
`ifdef OPERATOR_TEST_SIGNED_EN
            3'd6: exec_result = DATA_W'($signed(a_q) <= $signed(b_q));
            3'd7: exec_result = DATA_W'($signed(a_q) < $signed(b_q));
`else
            3'd6: exec_result = DATA_W'((a_q != '0) && (b_q != '0));
            3'd7: exec_result = DATA_W'(a_q < b_q);
`endif
            default: exec_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_state <= INITIAL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                arr[i] <= '0;
            end
        end else begin
            case (fsm_state)
                INITIAL: fsm_state <= START;
                START: begin
                    if (in1_valid && in1_ready) begin
                        a_q       <= in1;
                        fsm_state <= OPB;
                    end
                end
                OPB: begin
                    if (in1_valid) begin
                        b_q       <= in1;
                        op_q      <= op;
                        fsm_state <= EXEC;
                    end
                end
                EXEC: begin
                    arr[wr_ptr] <= exec_result;
                    // DEPTH is a power of two, so natural overflow is the wrap.
                    wr_ptr      <= wr_ptr + 1'b1;
                    fsm_state   <= START;
                end
                default: fsm_state <= INITIAL;
            endcase

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_operator_test_fsm.sv
// tb/tb_operator_test_fsm.sv - directed self-checking bench for operator_test_fsm
module tb_operator_test_fsm;

    logic        clk;
    logic        reset;
    logic [31:0] in1;
    logic        in1_valid;
    logic        in1_ready;
    logic [2:0]  op;
    logic [31:0] out1;
    logic        out1_valid;
    logic        out1_ready;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    operator_test_fsm #(.DATA_W(32), .DEPTH(8), .STATE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in1        (in1),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .op         (op),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one operand pair and returns with the FSM back in START after EXEC.
    // With pop_exec set, out1_ready is raised only during the EXEC cycle so the
    // write and the pop land on the same edge.
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                             input bit pop_exec, input logic [31:0] pop_exp);
        int n;
        n = 0;
        in1 = a;
        in1_valid = 1'b1;
        while (!in1_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("timeout_opa", 64'd1, 64'd0);
        step();
        in1 = b;
        op = o;
        step();
        in1_valid = 1'b0;
        if (pop_exec) begin
            out1_ready = 1'b1;
            check("exec_pop_data", out1, pop_exp);
        end
        step();
        out1_ready = 1'b0;
    endtask

    logic [31:0] exp_tab [8];
    logic [31:0] prev;

    initial begin
        reset = 1'b0;
        in1 = '0;
        in1_valid = 1'b0;
        op = '0;
        out1_ready = 1'b0;
        repeat (3) step();
        check("rst_out1_valid", out1_valid, 0);
        check("rst_count", count, 0);
        check("rst_in1_ready", in1_ready, 0);
        check("rst_out1", out1, 0);

        // Basic ADD with latency check
        reset = 1'b1;
        in1 = 32'd5;
        in1_valid = 1'b1;
        op = 3'd0;
        check("initial_not_ready", in1_ready, 0);
        step();
        check("start_ready", in1_ready, 1);
        step();
        in1 = 32'd7;
        step();
        in1_valid = 1'b0;
        check("exec_no_valid_yet", out1_valid, 0);
        step();
        check("add_out1", out1, 32'd12);
        check("add_valid", out1_valid, 1);
        check("add_count", count, 1);
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check("add_pop_count", count, 0);

        // EQ pairs, then drain
        send_pair(32'd0, 32'd1, 3'd5, 0, 0);
        send_pair(32'd3, 32'd3, 3'd5, 0, 0);
        check("eq_count", count, 2);
        check("eq_first", out1, 0);
        out1_ready = 1'b1;
        step();
        check("eq_second", out1, 1);
        step();
        out1_ready = 1'b0;
        check("eq_drain_count", count, 0);
        check("eq_drain_valid", out1_valid, 0);

        // Fill the array, confirm back-pressure and ignored operands
        for (int i = 0; i < 8; i++) send_pair(32'd100 + i, 32'd0, 3'd0, 0, 0);
        check("full_count", count, 8);
        check("full_not_ready", in1_ready, 0);
        in1 = 32'd99;
        in1_valid = 1'b1;
        repeat (3) step();
        check("full_still_not_ready", in1_ready, 0);
        check("full_count_held", count, 8);
        in1_valid = 1'b0;
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check("after_pop_ready", in1_ready, 1);
        check("after_pop_count", count, 7);
        out1_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("full_drain_data", out1, 32'd100 + i);
            step();
        end
        out1_ready = 1'b0;
        check("full_drain_count", count, 0);

        // Wrap-around arithmetic and the remaining operators
        send_pair(32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0);
        send_pair(32'd0, 32'd1, 3'd1, 0, 0);
        send_pair(32'hFFFF_FFFF, 32'd1, 3'd7, 0, 0);
        send_pair(32'h0000_F0F0, 32'h0000_0FF0, 3'd2, 0, 0);
        send_pair(32'h0000_F0F0, 32'h0000_0FF0, 3'd3, 0, 0);
        send_pair(32'h0000_F0F0, 32'h0000_0FF0, 3'd4, 0, 0);
        send_pair(32'h0000_F0F0, 32'h0000_0FF0, 3'd6, 0, 0);
        send_pair(32'hFFFF_FFFF, 32'd1, 3'd6, 0, 0);
        exp_tab[0] = 32'h0000_0000;
        exp_tab[1] = 32'hFFFF_FFFF;
`ifdef OPERATOR_TEST_SIGNED_EN
        exp_tab[2] = 32'd1;
        exp_tab[6] = 32'd0;
`else
        exp_tab[2] = 32'd0;
        exp_tab[6] = 32'd1;
`endif
        exp_tab[3] = 32'h0000_00F0;
        exp_tab[4] = 32'h0000_FFF0;
        exp_tab[5] = 32'h0000_FF00;
        exp_tab[7] = 32'd1;
        check("ops_count", count, 8);
        out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ops_result_%0d", i), out1, exp_tab[i]);
            step();
        end
        out1_ready = 1'b0;
        check("ops_drain_count", count, 0);

        // Simultaneous write and pop while pointers wrap
        send_pair(32'd1000, 32'd0, 3'd0, 0, 0);
        prev = 32'd1000;
        for (int i = 0; i < 20; i++) begin
            send_pair(i, i * 3, 3'd0, 1, prev);
            prev = i * 4;
            check("stream_count", count, 1);
        end
        check("stream_last", out1, 32'd76);
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check("stream_empty", count, 0);

        // Reset while a pair is half captured with results stored
        for (int i = 0; i < 3; i++) send_pair(i, 32'd1, 3'd0, 0, 0);
        check("pre_reset_count", count, 3);
        in1 = 32'd9;
        in1_valid = 1'b1;
        step();
        in1_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", out1_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_out1", out1, 0);
        check("midrst_ready", in1_ready, 0);
        step();
        reset = 1'b1;
        send_pair(32'd6, 32'd7, 3'd0, 0, 0);
        check("post_rst_out1", out1, 32'd13);
        check("post_rst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
